// File: rtl/uart_rx.sv
// 16x-oversampling UART receiver: 2-flop input synchronizer, free-running baud tick,
// IDLE/START/DATA/STOP FSM with mid-bit sampling, valid and frame-error pulses.
module uart_rx #(
    parameter int unsigned N        = 8,
    parameter int unsigned BAUD_DIV = 326,
    parameter int unsigned SB_TICK  = 16
) (
    input  logic         clk,
    input  logic         rst,
    input  logic         i_rx,
    output logic [N-1:0] o_data_rx,
    output logic         o_rx_valid,
    output logic         o_frame_err
);

    localparam int unsigned CW   = (BAUD_DIV > 1) ? $clog2(BAUD_DIV) : 1;
    localparam int unsigned SMax = (SB_TICK > 16) ? SB_TICK : 16;
    localparam int unsigned SW   = $clog2(SMax);
    localparam int unsigned NW   = (N > 1) ? $clog2(N) : 1;

    localparam logic [CW-1:0] CntLast = CW'(BAUD_DIV - 1);
    localparam logic [SW-1:0] SMid    = SW'(7);
    localparam logic [SW-1:0] SData   = SW'(15);
    localparam logic [SW-1:0] SStop   = SW'(SB_TICK - 1);
    localparam logic [NW-1:0] NLast   = NW'(N - 1);

    typedef enum logic [1:0] {
        StIdle,
        StStart,
        StData,
        StStop
    } state_e;

    logic          rx_meta_q, rx_s_q;
    logic [CW-1:0] cnt_q, cnt_d;
    logic          tick;
    state_e        state_q, state_d;
    logic [SW-1:0] s_q, s_d;
    logic [NW-1:0] n_q, n_d;
    logic [N-1:0]  shift_q, shift_d;
    logic [N-1:0]  data_q, data_d;
    logic          valid_q, valid_d;
    logic          err_q, err_d;

    assign tick  = (cnt_q == CntLast);
    assign cnt_d = tick ? '0 : cnt_q + 1'b1;

    always_comb begin
        state_d = state_q;
        s_d     = s_q;
        n_d     = n_q;
        shift_d = shift_q;
        data_d  = data_q;
        valid_d = 1'b0;
        err_d   = 1'b0;

        unique case (state_q)
            StIdle: begin
                if (!rx_s_q) begin
                    state_d = StStart;
                    s_d     = '0;
                end
            end

            StStart: begin
                if (tick) begin
                    if (s_q == SMid) begin
                        // Line must still be low at mid start bit, else it was a glitch.
                        if (!rx_s_q) begin
                            state_d = StData;
                            s_d     = '0;
                            n_d     = '0;
                        end else begin
                            state_d = StIdle;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            StData: begin
                if (tick) begin
                    if (s_q == SData) begin
                        s_d     = '0;
                        n_d     = n_q + 1'b1;
                        shift_d = (shift_q >> 1) | (N'(rx_s_q) << (N - 1));
                        if (n_q == NLast) begin
                            state_d = StStop;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            StStop: begin
                if (tick) begin
                    if (s_q == SStop) begin
                        state_d = StIdle;
                        if (rx_s_q) begin
                            data_d  = shift_q;
                            valid_d = 1'b1;
                        end else begin
                            err_d = 1'b1;
                        end
                    end else begin
                        s_d = s_q + 1'b1;
                    end
                end
            end

            default: state_d = StIdle;
        endcase
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            rx_meta_q <= 1'b1;
            rx_s_q    <= 1'b1;
            cnt_q     <= '0;
            state_q   <= StIdle;
            s_q       <= '0;
            n_q       <= '0;
            shift_q   <= '0;
            data_q    <= '0;
            valid_q   <= 1'b0;
            err_q     <= 1'b0;
        end else begin
            rx_meta_q <= i_rx;
            rx_s_q    <= rx_meta_q;
            cnt_q     <= cnt_d;
            state_q   <= state_d;
            s_q       <= s_d;
            n_q       <= n_d;
            shift_q   <= shift_d;
            data_q    <= data_d;
            valid_q   <= valid_d;
            err_q     <= err_d;
        end
    end

    assign o_data_rx   = data_q;
    assign o_rx_valid  = valid_q;
    assign o_frame_err = err_q;

endmodule

// File: tb/tb_uart_rx.sv
// Scoreboard bench for uart_rx: frames are queued as expected pulses when sent, and a
// monitor pops and compares on every valid/error pulse.
module tb_uart_rx;

    localparam int unsigned N        = 8;
    localparam int unsigned BAUD_DIV = 4;
    localparam int unsigned SB_TICK  = 16;
    localparam int unsigned BIT_CLK  = 16 * BAUD_DIV;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic       i_rx = 1'b1;
    logic [7:0] o_data_rx;
    logic       o_rx_valid;
    logic       o_frame_err;

    always #5 clk = ~clk;

    uart_rx #(
        .N       (N),
        .BAUD_DIV(BAUD_DIV),
        .SB_TICK (SB_TICK)
    ) dut (
        .clk        (clk),
        .rst        (rst),
        .i_rx       (i_rx),
        .o_data_rx  (o_data_rx),
        .o_rx_valid (o_rx_valid),
        .o_frame_err(o_frame_err)
    );

    typedef struct packed {
        logic       is_err;
        logic [7:0] data;
    } exp_t;

    exp_t       exp_q[$];
    int         checks = 0;
    int         errors = 0;
    logic [7:0] last_good = 8'h00;
    int         n_valid_exp = 0;
    int         n_valid_seen = 0;
    longint     cyc = 0;
    longint     last_valid_cyc = 0;
    bit         have_last = 1'b0;

    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, req);
        end
    endtask

    // Monitor: every pulse must match the oldest outstanding expectation.
    always @(negedge clk) begin
        if (rst && (o_rx_valid || o_frame_err)) begin
            exp_t e;
            check("pulse_exclusive", 32'(o_rx_valid & o_frame_err), 32'd0);
            if (exp_q.size() == 0) begin
                check("unexpected_pulse", {30'd0, o_rx_valid, o_frame_err}, 32'd0);
            end else begin
                e = exp_q.pop_front();
                check("pulse_kind", 32'(o_frame_err), 32'(e.is_err));
                check("rx_data", 32'(o_data_rx), 32'(e.data));
            end
            if (o_rx_valid) begin
                n_valid_seen++;
                if (have_last) begin
                    check("valid_spacing_ge_640", 32'((cyc - last_valid_cyc) >= 640), 32'd1);
                end
                last_valid_cyc = cyc;
                have_last      = 1'b1;
            end
        end
    end

    task automatic drive_bit(input logic b, input int unsigned clks);
        i_rx = b;
        repeat (clks) @(negedge clk);
    endtask

    task automatic send_frame(input logic [7:0] d, input bit bad_stop);
        exp_t e;
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 8; i++) drive_bit(d[i], BIT_CLK);
        if (bad_stop) begin
            e.is_err = 1'b1;
            e.data   = last_good;
            exp_q.push_back(e);
            // Low across the stop sample point, then idle for the rest of the bit.
            drive_bit(1'b0, 48);
            drive_bit(1'b1, BIT_CLK - 48);
        end else begin
            last_good = d;
            e.is_err  = 1'b0;
            e.data    = d;
            exp_q.push_back(e);
            n_valid_exp++;
            drive_bit(1'b1, BIT_CLK);
        end
    endtask

    task automatic drain(input string name);
        for (int i = 0; i < 200 && exp_q.size() != 0; i++) @(negedge clk);
        check(name, 32'(exp_q.size()), 32'd0);
    endtask

    initial begin
        #2_000_000;
        $display("FAIL watchdog: got timeout, expected completion");
        $fatal(1, "watchdog expired");
    end

    initial begin
        i_rx = 1'b1;
        rst  = 1'b0;
        repeat (5) @(negedge clk);
        check("reset_data", 32'(o_data_rx), 32'd0);
        check("reset_valid", 32'(o_rx_valid), 32'd0);
        check("reset_err", 32'(o_frame_err), 32'd0);
        rst = 1'b1;
        drive_bit(1'b1, 20);

        send_frame(8'h35, 1'b0);
        drive_bit(1'b1, 100);
        drain("drain_0x35");
        check("hold_0x35", 32'(o_data_rx), 32'h35);

        send_frame(8'h01, 1'b0);
        send_frame(8'h02, 1'b0);
        send_frame(8'h03, 1'b0);
        drive_bit(1'b1, 50);
        drain("drain_b2b");

        // Short low glitch: must be rejected, then a normal frame must still land.
        drive_bit(1'b0, 12);
        drive_bit(1'b1, 150);
        check("glitch_no_pulse", 32'(exp_q.size()), 32'd0);
        send_frame(8'h3C, 1'b0);
        drive_bit(1'b1, 50);
        drain("drain_after_glitch");

        send_frame(8'hA5, 1'b1);
        drive_bit(1'b1, BIT_CLK);
        drain("drain_frame_err");
        check("data_hold_after_err", 32'(o_data_rx), 32'h3C);

        // Abort 0xFF in data bit 4 with an asynchronous reset.
        drive_bit(1'b0, BIT_CLK);
        for (int i = 0; i < 4; i++) drive_bit(1'b1, BIT_CLK);
        drive_bit(1'b1, 20);
        #3;
        rst = 1'b0;
        #1;
        check("async_rst_data", 32'(o_data_rx), 32'd0);
        check("async_rst_valid", 32'(o_rx_valid), 32'd0);
        check("async_rst_err", 32'(o_frame_err), 32'd0);
        last_good = 8'h00;
        repeat (10) @(negedge clk);
        check("in_rst_data", 32'(o_data_rx), 32'd0);
        rst = 1'b1;
        drive_bit(1'b1, 50);
        send_frame(8'h5A, 1'b0);
        drive_bit(1'b1, 50);
        drain("drain_after_reset");

        send_frame(8'h00, 1'b0);
        send_frame(8'hFF, 1'b0);
        drive_bit(1'b1, 50);
        drain("drain_extremes");

        for (int k = 0; k < 30; k++) begin
            logic [7:0]  d;
            bit          bad;
            int unsigned gap;
            d   = 8'($urandom);
            bad = ($urandom_range(0, 5) == 0);
            if (bad) gap = BIT_CLK + $urandom_range(0, 40);
            else if ($urandom_range(0, 2) == 0) gap = 0;
            else gap = $urandom_range(1, 80);
            send_frame(d, bad);
            if (gap != 0) drive_bit(1'b1, gap);
        end
        drive_bit(1'b1, 100);
        drain("drain_random");
        check("valid_count", 32'(n_valid_seen), 32'(n_valid_exp));

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/uart_rx.md
UART_RX -- requirements
Module: uart_rx

Interface
REQ-001 Parameter N, default 8: number of data bits per frame.
REQ-002 Parameter BAUD_DIV, default 326: clk cycles per oversampling tick (16 ticks per bit).
REQ-003 Parameter SB_TICK, default 16: ticks in the stop interval (16 means 1 stop bit).
REQ-004 Port clk, input, 1 bit: the single clock; all state updates on its rising edge.
REQ-005 Port rst, input, 1 bit: reset, asynchronous and active-low.
REQ-006 Port i_rx, input, 1 bit: serial line, idle high, asynchronous to clk.
REQ-007 Port o_data_rx, output, N bits: last correctly received byte, LSB received first.
REQ-008 Port o_rx_valid, output, 1 bit: one-cycle pulse when o_data_rx is updated.
REQ-009 Port o_frame_err, output, 1 bit: one-cycle pulse when the stop bit samples low.

Function
REQ-010 i_rx SHALL pass through a 2-flop synchronizer (reset value 1); all logic uses the synchronized line rx_s.
REQ-011 The tick counter SHALL count 0..BAUD_DIV-1 continuously and assert a one-cycle tick when it reaches BAUD_DIV-1, then wrap to 0.
REQ-012 The FSM SHALL have four states: IDLE, START, DATA, STOP.
REQ-013 IDLE: when rx_s=0, go to START and clear the tick count s; otherwise stay in IDLE.
REQ-014 START: on each tick increment s; at s=7 (mid start bit), rx_s=0 goes to DATA with s=0 and bit count n=0, and rx_s=1 is a false start that returns to IDLE with no output pulse.
REQ-015 DATA: on each tick increment s; at s=15, shift rx_s into the MSB of the shift register (shift right), reset s=0, and increment n.
REQ-016 DATA: after the sample with n=N-1, go to STOP.
REQ-017 STOP: on each tick increment s; at s=SB_TICK-1, sample rx_s and return to IDLE.
REQ-018 STOP with rx_s=1: load o_data_rx from the shift register and pulse o_rx_valid on the following clk cycle.
REQ-019 STOP with rx_s=0: pulse o_frame_err, do not pulse o_rx_valid, and leave o_data_rx unchanged.
REQ-020 o_data_rx SHALL hold its value between frames; o_rx_valid and o_frame_err SHALL never be asserted together.
REQ-021 A start edge arriving in the same cycle as the return to IDLE SHALL be detected on the next cycle; back-to-back frames SHALL be received with no dropped frame.
REQ-022 The line level during IDLE SHALL not affect any output.
REQ-023 o_rx_valid pulses SHALL be spaced at least 10*16*BAUD_DIV clk cycles apart, so downstream needs no back-pressure; the block has no ready input.

Reset
REQ-024 While rst=0, all of the following SHALL hold immediately and asynchronously: state=IDLE, s=0, n=0, tick counter=0, shift register=0, synchronizer flops=1, o_data_rx=0, o_rx_valid=0, o_frame_err=0.
REQ-025 Reset asserted mid-frame SHALL abort the frame with no pulse.
REQ-026 After reset deasserts, the first falling edge on i_rx SHALL start a new frame.

Verification (BAUD_DIV=4, so 1 bit = 64 clk)
REQ-027 Send frame 0x35 (8N1) -> o_data_rx=0x35, one-cycle o_rx_valid, o_frame_err=0 throughout.
REQ-028 Send 0x01, 0x02, 0x03 back-to-back -> three valid pulses with data 0x01, 0x02, 0x03 in order.
REQ-029 Hold i_rx low for 12 clk, then high -> no o_rx_valid, no o_frame_err, FSM back in IDLE.
REQ-030 Send 0xA5 with the stop bit driven low -> o_frame_err pulses once, no o_rx_valid, o_data_rx keeps its prior value.
REQ-031 Assert rst during data bit 4 of 0xFF, release, then send 0x5A -> all outputs 0 during reset, then a single valid pulse with 0x5A.
REQ-032 Send 0x00 then 0xFF -> data is correct at both extremes, and valid pulses are spaced at least 640 clk apart.
